test_status_dev: RTL and testbench

Memory-mapped test-status and console responder on the SoC data bus. Firmware running on rvcore stores its done flag, pass/fail result, diagnostic code and console characters here, so the core reports its own result instead of the bench polling architectural registers. Outputs drive the simulation top directly. A built-in watchdog flags runaway programs.

---
 rtl/test_status_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/test_status_dev.sv | 144 ++++++++++++++
 tb/tb_test_status_dev.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status/console responder: register offsets,
// watchdog default and the address decode helper.
package test_status_pkg;

    localparam logic [7:0] TS_DONE    = 8'h00;
    localparam logic [7:0] TS_RESULT  = 8'h04;
    localparam logic [7:0] TS_CODE    = 8'h08;
    localparam logic [7:0] TS_CONSOLE = 8'h0C;
    localparam logic [7:0] TS_CYCLES  = 8'h10;
    localparam logic [7:0] TS_WDOG    = 8'h14;

    localparam int unsigned TS_WDOG_RESET = 5000;

    typedef enum logic [2:0] {
        REG_DONE,
        REG_RESULT,
        REG_CODE,
        REG_CONSOLE,
        REG_CYCLES,
        REG_WDOG,
        REG_NONE
    } ts_reg_e;

    // Byte lanes are ignored: only the word offset selects a register.
    function automatic ts_reg_e ts_decode(input logic [7:0] addr);
        logic [7:0] word_addr;
        word_addr = {addr[7:2], 2'b00};
        case (word_addr)
            TS_DONE:    return REG_DONE;
            TS_RESULT:  return REG_RESULT;
            TS_CODE:    return REG_CODE;
            TS_CONSOLE: return REG_CONSOLE;
            TS_CYCLES:  return REG_CYCLES;
            TS_WDOG:    return REG_WDOG;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come from pointers carrying one extra wrap bit.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/test_status_dev.sv
// Memory-mapped test-status block: done/result/code registers, cycle counter
// with watchdog, and a console byte FIFO drained by the simulation top.
module test_status_dev
    import test_status_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WDOG_RESET = TS_WDOG_RESET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_gnt,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] code_o,
    output logic        timeout_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i
);

    ts_reg_e     sel;
    logic        wr;
    logic        rd;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;

    logic        done_r;
    logic        result_r;
    logic        timeout_r;
    logic        rvalid_r;
    logic [31:0] code_r;
    logic [31:0] cycles_r;
    logic [31:0] limit_r;
    logic [31:0] rdata_r;
    logic [31:0] rd_mux;

    logic        counting;
    logic        wdog_wr;
    logic        done_set;
    logic        timeout_set;

    assign sel = ts_decode(bus_addr);

    // Only a console push into a full FIFO stalls; everything else is granted.
    assign bus_gnt = bus_req && !(bus_we && (sel == REG_CONSOLE) && fifo_full);
    assign wr      = bus_gnt && bus_we;
    assign rd      = bus_gnt && !bus_we;

    assign fifo_push = wr && (sel == REG_CONSOLE);
    assign fifo_pop  = !fifo_empty && con_ready_i;

    assign counting = !done_r && !timeout_r;
    assign wdog_wr  = wr && (sel == REG_WDOG);
    assign done_set = wr && (sel == REG_DONE) && bus_wdata[0] && counting;
    // Timeout fires on the edge that completes the limit-th counted cycle;
    // a same-cycle DONE write wins so the two flags stay exclusive.
    assign timeout_set = counting && !wdog_wr && !done_set
                         && (limit_r != '0) && (cycles_r == limit_r - 32'd1);

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_DONE:    rd_mux = {31'b0, done_r};
            REG_RESULT:  rd_mux = {31'b0, result_r};
            REG_CODE:    rd_mux = code_r;
            REG_CONSOLE: rd_mux = {30'b0, fifo_full, fifo_empty};
            REG_CYCLES:  rd_mux = cycles_r;
            REG_WDOG:    rd_mux = limit_r;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r    <= 1'b0;
            result_r  <= 1'b0;
            timeout_r <= 1'b0;
            rvalid_r  <= 1'b0;
            code_r    <= '0;
            cycles_r  <= '0;
            limit_r   <= WDOG_RESET;
            rdata_r   <= '0;
        end else begin
            rvalid_r <= rd;
            rdata_r  <= rd ? rd_mux : '0;

            if (done_set) begin
                done_r <= 1'b1;
            end
            if (timeout_set) begin
                timeout_r <= 1'b1;
            end

            if (wr && !done_r) begin
                if (sel == REG_RESULT) begin
                    result_r <= bus_wdata[0];
                end
                if (sel == REG_CODE) begin
                    code_r <= bus_wdata;
                end
            end

            if (wdog_wr) begin
                limit_r  <= bus_wdata;
                cycles_r <= '0;
            end else if (counting && (cycles_r != '1)) begin
                cycles_r <= cycles_r + 32'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus_rvalid  = rvalid_r;
    assign bus_rdata   = rdata_r;
    assign done_o      = done_r;
    assign pass_o      = result_r && done_r;
    assign code_o      = code_r;
    assign timeout_o   = timeout_r;
    assign con_valid_o = !fifo_empty;
    assign con_data_o  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_test_status_dev.sv
// Randomized bench for test_status_dev against a transaction-level reference
// model, plus directed scenarios for watchdog, done/result, FIFO and reset.
`timescale 1ns/1ps
module tb_test_status_dev;
    import test_status_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        con_ready_i = 1'b0;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        done_o;
    logic        pass_o;
    logic [31:0] code_o;
    logic        timeout_o;
    logic        con_valid_o;
    logic [7:0]  con_data_o;

    test_status_dev #(
        .FIFO_DEPTH (DEPTH),
        .WDOG_RESET (5000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .code_o      (code_o),
        .timeout_o   (timeout_o),
        .con_valid_o (con_valid_o),
        .con_data_o  (con_data_o),
        .con_ready_i (con_ready_i)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: architectural state only, updated once per clock edge.
    bit          m_done, m_result, m_timeout, m_rvalid;
    logic [31:0] m_code, m_limit, m_rdata;
    longint      m_cycles;
    logic [7:0]  m_q[$];
    logic [7:0]  got_q[$];

    task automatic model_reset();
        m_done = 0; m_result = 0; m_timeout = 0; m_rvalid = 0;
        m_code = '0; m_limit = 32'd5000; m_rdata = '0; m_cycles = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit gnt);
        int          idx;
        bit          wr, rd, counting, done_set;
        logic [31:0] v;
        idx = int'(bus_addr[7:2]);
        wr  = gnt && bus_we;
        rd  = gnt && !bus_we;
        v   = '0;
        if (rd) begin
            case (idx)
                0: v = 32'(m_done);
                1: v = 32'(m_result);
                2: v = m_code;
                3: v = {30'b0, m_q.size() == DEPTH, m_q.size() == 0};
                4: v = 32'(m_cycles);
                5: v = m_limit;
                default: v = '0;
            endcase
        end
        m_rvalid = rd;
        m_rdata  = v;
        if (m_q.size() != 0 && con_ready_i) void'(m_q.pop_front());
        if (wr && idx == 3) m_q.push_back(bus_wdata[7:0]);
        counting = !m_done && !m_timeout;
        done_set = wr && idx == 0 && bus_wdata[0] && counting;
        if (wr && idx == 5) begin
            m_limit  = bus_wdata;
            m_cycles = 0;
        end else if (counting && m_cycles < 64'hFFFF_FFFF) begin
            m_cycles++;
            if (!done_set && m_limit != 0 && m_cycles == longint'(m_limit)) m_timeout = 1;
        end
        if (wr && !m_done) begin
            if (idx == 1) m_result = bus_wdata[0];
            if (idx == 2) m_code = bus_wdata;
        end
        if (done_set) m_done = 1;
    endtask

    task automatic check_outputs();
        check("done_o", 32'(done_o), 32'(m_done));
        check("pass_o", 32'(pass_o), 32'(m_done & m_result));
        check("code_o", code_o, m_code);
        check("timeout_o", 32'(timeout_o), 32'(m_timeout));
        check("con_valid_o", 32'(con_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("con_data_o", 32'(con_data_o), 32'(m_q[0]));
        check("bus_rvalid", 32'(bus_rvalid), 32'(m_rvalid));
        check("bus_rdata", bus_rdata, m_rdata);
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic step(output bit exp_g, output bit dut_g);
        #4;
        exp_g = bus_req && !(bus_we && bus_addr[7:2] == 6'd3 && m_q.size() == DEPTH);
        dut_g = bus_gnt;
        check("bus_gnt", 32'(bus_gnt), 32'(exp_g));
        if (con_valid_o && con_ready_i) got_q.push_back(con_data_o);
        @(posedge clk);
        model_edge(exp_g);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        bit eg, dg;
        bus_req = 0; bus_we = 0;
        step(eg, dg);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bit eg, dg;
        int unsigned n;
        n = 0;
        bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
        do begin
            step(eg, dg);
            n++;
        end while (!dg && n < 20);
        check("write_granted", 32'(dg), 32'd1);
        bus_req = 0; bus_we = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bit eg, dg;
        bus_req = 1; bus_we = 0; bus_addr = a;
        step(eg, dg);
        d = bus_rdata;
        bus_req = 0;
    endtask

    task automatic do_reset();
        #2;
        bus_req = 0; bus_we = 0; con_ready_i = 0;
        rst_n = 0;
        #1;
        check("rst_gnt", 32'(bus_gnt), 32'd0);
        check("rst_rvalid", 32'(bus_rvalid), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_pass", 32'(pass_o), 32'd0);
        check("rst_code", code_o, 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_con_valid", 32'(con_valid_o), 32'd0);
        check("rst_con_data", 32'(con_data_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        model_edge(1'b0);
        #1;
        check_outputs();
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] rv;
        int unsigned n;
        bit eg, dg;

        // Watchdog from reset: 5000 counted cycles, the release edge being the first.
        do_reset();
        n = 1;
        while (!timeout_o && n < 6000) begin
            idle();
            n++;
        end
        check("wdog_reset_cycles", n, 32'd5000);
        check("wdog_reset_done", 32'(done_o), 32'd0);
        bus_read(TS_CYCLES, rv);
        check("wdog_cycles_read", rv, 32'd5000);

        // Passing program; RESULT frozen after DONE.
        do_reset();
        bus_write(TS_CODE, 32'hDEAD_BEEF);
        bus_write(TS_RESULT, 32'd1);
        bus_write(TS_DONE, 32'd1);
        check("pass_done", 32'(done_o), 32'd1);
        check("pass_pass", 32'(pass_o), 32'd1);
        check("pass_code", code_o, 32'hDEAD_BEEF);
        bus_write(TS_RESULT, 32'd0);
        check("pass_frozen", 32'(pass_o), 32'd1);

        // Failing program; cycle counter stops at the DONE edge (3 counted edges).
        do_reset();
        bus_write(TS_RESULT, 32'd0);
        bus_write(TS_DONE, 32'd1);
        check("fail_done", 32'(done_o), 32'd1);
        check("fail_pass", 32'(pass_o), 32'd0);
        bus_read(TS_CYCLES, rv);
        check("fail_cycles_a", rv, 32'd3);
        repeat (5) idle();
        bus_read(TS_CYCLES, rv);
        check("fail_cycles_b", rv, 32'd3);

        // Console FIFO fill, stall, and ordered drain.
        do_reset();
        got_q.delete();
        for (int i = 0; i < 8; i++) bus_write(TS_CONSOLE, 32'h41 + 32'(i));
        bus_req = 1; bus_we = 1; bus_addr = TS_CONSOLE; bus_wdata = 32'h49;
        step(eg, dg);
        check("fifo_9th_stall", 32'(dg), 32'd0);
        bus_req = 0;
        bus_read(TS_CONSOLE, rv);
        check("fifo_full_status", rv, 32'd2);
        bus_req = 1; bus_we = 1; bus_addr = TS_CONSOLE; bus_wdata = 32'h49;
        con_ready_i = 1;
        step(eg, dg);
        check("fifo_pop_cycle_gnt", 32'(dg), 32'd0);
        step(eg, dg);
        check("fifo_next_cycle_gnt", 32'(dg), 32'd1);
        bus_req = 0; bus_we = 0;
        n = 0;
        while (con_valid_o && n < 20) begin
            idle();
            n++;
        end
        check("fifo_drain_count", got_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            check("fifo_order", 32'(got_q[i]), 32'h41 + 32'(i));
        con_ready_i = 0;

        // Programmed watchdog limit of 10, then disabled watchdog.
        do_reset();
        repeat (98) idle();
        bus_write(TS_WDOG, 32'd10);
        bus_read(TS_CYCLES, rv);
        check("wdog10_cleared", rv, 32'd0);
        n = 1;
        while (!timeout_o && n < 50) begin
            idle();
            n++;
        end
        check("wdog10_cycles", n, 32'd10);
        do_reset();
        bus_write(TS_WDOG, 32'd0);
        repeat (200) idle();
        check("wdog0_no_timeout", 32'(timeout_o), 32'd0);
        bus_read(TS_WDOG, rv);
        check("wdog0_limit", rv, 32'd0);

        // Reset during a pending read with a full FIFO.
        do_reset();
        for (int i = 0; i < 8; i++) bus_write(TS_CONSOLE, 32'(i));
        bus_read(TS_CODE, rv);
        check("pending_rvalid", 32'(bus_rvalid), 32'd1);
        do_reset();
        bus_read(TS_CONSOLE, rv);
        check("post_rst_empty", rv, 32'd1);
        bus_read(TS_WDOG, rv);
        check("post_rst_limit", rv, 32'd5000);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                int unsigned r;
                int unsigned w;
                r = $urandom_range(0, 99);
                if (r < 40)      w = 3;
                else if (r < 50) w = 0;
                else if (r < 60) w = 1;
                else if (r < 70) w = 2;
                else if (r < 80) w = 4;
                else if (r < 88) w = 5;
                else             w = $urandom_range(6, 63);
                bus_req     = ($urandom_range(0, 3) != 0);
                bus_we      = ($urandom_range(0, 1) != 0);
                con_ready_i = ($urandom_range(0, 1) != 0);
                bus_addr    = {w[5:0], 2'($urandom_range(0, 3))};
                if (w == 0)      bus_wdata = {$urandom_range(0, 65535), 15'b0, ($urandom_range(0, 15) == 0)};
                else if (w == 5) bus_wdata = $urandom_range(0, 40);
                else             bus_wdata = $urandom;
                step(eg, dg);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
